mcb_rd_unpacker: RTL and testbench

//  Read-path stage directly downstream of mcb_instr_ctrl. It captures MCB port read data

---
 rtl/mcb_rd_unpacker_if.sv | 25 ++
 rtl/mcb_rd_unpacker.sv | 99 +++++++++
 tb/tb_mcb_rd_unpacker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mcb_rd_unpacker_if.sv
// mcb_rd_unpacker_if: MCB read-FIFO pop side and read-path outFIFO write side of the unpacker.
interface mcb_rd_unpacker_if #(
    parameter int DWIDTH = 64,
    parameter int OWIDTH = 16,
    parameter int OCNT_W = 11
);
    logic              mcb_rd_en_i;
    logic              mcb_rd_empty_i;
    logic [DWIDTH-1:0] mcb_rd_data_i;
    logic              out_full_i;
    logic [OCNT_W-1:0] out_wr_count_i;
    logic              out_wr_en_o;
    logic [OWIDTH-1:0] out_din_o;
    logic              out_prog_full_o;

    modport master (
        output mcb_rd_en_i, mcb_rd_empty_i, mcb_rd_data_i, out_full_i, out_wr_count_i,
        input  out_wr_en_o, out_din_o, out_prog_full_o
    );

    modport slave (
        input  mcb_rd_en_i, mcb_rd_empty_i, mcb_rd_data_i, out_full_i, out_wr_count_i,
        output out_wr_en_o, out_din_o, out_prog_full_o
    );
endinterface

// File: rtl/mcb_rd_unpacker.sv
// mcb_rd_unpacker: captures MCB read words into a skid FIFO and serializes them LSB-beat-first into the outFIFO.
module mcb_rd_unpacker #(
    parameter int DWIDTH     = 64,
    parameter int OWIDTH     = 16,
    parameter int SKID_DEPTH = 4,
    parameter int OCNT_W     = 11,
    parameter int PF_THRESH  = 1536
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic [29:0]       xfer_len_i,
    mcb_rd_unpacker_if.slave  bus,
    output logic [29:0]       words_done_o,
    output logic              xfer_done_o,
    output logic              err_underflow_o,
    output logic              err_overflow_o
);
    localparam int RATIO = DWIDTH / OWIDTH;
    localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int AW    = $clog2(SKID_DEPTH);
    localparam int PW    = OCNT_W + 8;
    localparam logic [IW-1:0] LAST     = IW'(RATIO - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(SKID_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] mem_q [SKID_DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              cap_v_q, wr_en_q, wr_en_d, pf_q, done_q, unf_q, ovf_q;
    logic [OWIDTH-1:0] din_q, din_d;
    logic [29:0]       words_q, words_d;
    logic [DWIDTH-1:0] head;
    logic              emit, deq, enq, drop;
    logic [PW-1:0]     pf_sum;

    always_comb begin
        head    = mem_q[rp_q];
        emit    = ~bus.out_full_i & (state_q == SHIFT || cnt_q != '0);
        deq     = emit & (idx_q == LAST);
        // a last-beat pop in the same cycle frees the slot the capture needs
        drop    = cap_v_q & (cnt_q == FULL_CNT) & ~deq;
        enq     = cap_v_q & ~drop;
        cnt_d   = cnt_q + (AW + 1)'(enq) - (AW + 1)'(deq);
        idx_d   = deq ? '0 : idx_q + IW'(emit);
        wr_en_d = emit;
        din_d   = emit ? head[idx_q*OWIDTH +: OWIDTH] : din_q;
        words_d = (deq && words_q != '1) ? words_q + 30'd1 : words_q;
        state_d = cnt_d != '0 ? SHIFT : IDLE;
        pf_sum  = PW'(bus.out_wr_count_i) + PW'(cnt_q) * PW'(RATIO) + (cap_v_q ? PW'(RATIO) : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            cap_v_q <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_en_q <= 1'b0;
            din_q   <= '0;
            words_q <= '0;
            done_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_v_q <= bus.mcb_rd_en_i & ~bus.mcb_rd_empty_i;
            wp_q    <= wp_q + AW'(enq);
            rp_q    <= rp_q + AW'(deq);
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_en_q <= wr_en_d;
            din_q   <= din_d;
            words_q <= words_d;
            done_q  <= done_q | (xfer_len_i != '0 && words_q == xfer_len_i);
            unf_q   <= unf_q | (bus.mcb_rd_en_i & bus.mcb_rd_empty_i);
            ovf_q   <= ovf_q | drop;
            pf_q    <= pf_sum >= PW'(PF_THRESH);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wp_q] <= bus.mcb_rd_data_i;
    end

    assign bus.out_wr_en_o     = wr_en_q;
    assign bus.out_din_o       = din_q;
    assign bus.out_prog_full_o = pf_q;
    assign words_done_o        = words_q;
    assign xfer_done_o         = done_q;
    assign err_underflow_o     = unf_q;
    assign err_overflow_o      = ovf_q;
endmodule

// File: tb/tb_mcb_rd_unpacker.sv
// tb_mcb_rd_unpacker: scoreboard bench; popped words queue their expected beats, a monitor checks every outFIFO write.
`timescale 1ns/1ps
module tb_mcb_rd_unpacker;
    logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic [29:0] xfer_len = '0;
    logic [29:0] words_done;
    logic        xfer_done, e_unf, e_ovf;

    always #5 clk = ~clk;

    mcb_rd_unpacker_if #(.DWIDTH(64), .OWIDTH(16), .OCNT_W(11)) b ();

    mcb_rd_unpacker #(.DWIDTH(64), .OWIDTH(16), .SKID_DEPTH(4), .OCNT_W(11), .PF_THRESH(1536)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .xfer_len_i(xfer_len), .bus(b),
        .words_done_o(words_done), .xfer_done_o(xfer_done),
        .err_underflow_o(e_unf), .err_overflow_o(e_ovf)
    );

    int          compared = 0, mismatched = 0, cyc = 0, done_cyc = -1;
    logic [15:0] exp_q[$];
    int          beat_cyc[$];
    logic [15:0] e_beat;
    logic        pend_v = 1'b0;
    logic [63:0] pend_w = '0;
    bit          keep = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (xfer_done && done_cyc < 0) done_cyc = cyc;
        if (b.out_wr_en_o) begin
            beat_cyc.push_back(cyc);
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL beat: unexpected write din=%h, none required", b.out_din_o);
            end else begin
                e_beat = exp_q.pop_front();
                if (b.out_din_o !== e_beat) begin
                    mismatched++;
                    $display("FAIL beat: got %h required %h", b.out_din_o, e_beat);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", n, got, req);
        end
    endtask

    // data for a pop is presented in the cycle after the pop
    task automatic step(input logic en, input logic emp, input logic [63:0] w);
        b.mcb_rd_data_i = pend_v ? pend_w : {$urandom, $urandom};
        b.mcb_rd_en_i   = en;
        b.mcb_rd_empty_i = emp;
        pend_v = en & ~emp;
        pend_w = w;
        if (pend_v && keep) for (int i = 0; i < 4; i++) exp_q.push_back(w[i*16 +: 16]);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 64'h0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1'b0, 1'b1, 64'h0);
        clear = 1'b0;
        exp_q.delete();
        beat_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic drain(input string n, input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) step(1'b0, 1'b1, 64'h0);
        chk(n, exp_q.size(), 0);
    endtask

    initial begin
        int p, npop;
        logic en, emp;
        b.mcb_rd_en_i = 1'b0;
        b.mcb_rd_empty_i = 1'b1;
        b.mcb_rd_data_i = '0;
        b.out_full_i = 1'b0;
        b.out_wr_count_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {b.out_wr_en_o, b.out_din_o, b.out_prog_full_o, words_done, xfer_done, e_unf, e_ovf}, 0);
        rst = 1'b0;

        p = cyc;
        step(1'b1, 1'b0, 64'h4444_3333_2222_1111);
        idle(8);
        chk("t1_nbeats", beat_cyc.size(), 4);
        if (beat_cyc.size() >= 4) begin
            chk("t1_first_lat", beat_cyc[0] - p, 3);
            chk("t1_last_lat", beat_cyc[3] - p, 6);
        end
        chk("t1_words", words_done, 1);

        do_clear();
        xfer_len = 30'd8;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, {$urandom, $urandom});
            idle(3);
        end
        drain("t2_drain", 40);
        idle(3);
        chk("t2_nbeats", beat_cyc.size(), 32);
        if (beat_cyc.size() >= 32) begin
            chk("t2_no_gap", beat_cyc[31] - beat_cyc[0], 31);
            chk("t2_done_lat", done_cyc - beat_cyc[31], 1);
        end
        chk("t2_words", words_done, 8);
        chk("t2_done", xfer_done, 1);

        do_clear();
        chk("clear_done", xfer_done, 0);
        xfer_len = '0;
        b.out_full_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            keep = (i < 4);
            step(1'b1, 1'b0, {$urandom, $urandom});
        end
        keep = 1'b1;
        idle(2);
        chk("t3_ovf", e_ovf, 1);
        chk("t3_held", beat_cyc.size(), 0);
        b.out_full_i = 1'b0;
        drain("t3_drain", 40);
        idle(2);
        chk("t3_words", words_done, 4);

        do_clear();
        b.out_full_i = 1'b1;
        b.out_wr_count_i = 11'd1530;
        step(1'b1, 1'b0, {$urandom, $urandom});
        step(1'b1, 1'b0, {$urandom, $urandom});
        idle(4);
        chk("t4_pf_1538", b.out_prog_full_o, 1);
        b.out_wr_count_i = 11'd1527;
        idle(2);
        chk("t4_pf_1535", b.out_prog_full_o, 0);
        b.out_wr_count_i = 11'd1528;
        idle(2);
        chk("t4_pf_1536", b.out_prog_full_o, 1);
        b.out_wr_count_i = 11'd1527;
        b.out_full_i = 1'b0;
        drain("t4_drain", 20);
        idle(2);
        chk("t4_pf_empty", b.out_prog_full_o, 0);
        b.out_wr_count_i = '0;

        do_clear();
        chk("t5_unf_clr", e_unf, 0);
        step(1'b1, 1'b1, 64'h0);
        chk("t5_unf", e_unf, 1);
        idle(5);
        chk("t5_no_write", beat_cyc.size(), 0);

        do_clear();
        b.out_full_i = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, {$urandom, $urandom});
        idle(3);
        b.out_full_i = 1'b0;
        idle(2);
        b.out_full_i = 1'b1;
        idle(2);
        chk("t6_two_beats", beat_cyc.size(), 2);
        clear = 1'b1;
        step(1'b0, 1'b1, 64'h0);
        clear = 1'b0;
        exp_q.delete();
        chk("t6_clear_outs", {b.out_wr_en_o, b.out_din_o, b.out_prog_full_o, words_done, xfer_done, e_unf, e_ovf}, 0);
        beat_cyc.delete();
        b.out_full_i = 1'b0;
        idle(6);
        chk("t6_quiet", beat_cyc.size(), 0);
        step(1'b1, 1'b0, {$urandom, $urandom});
        drain("t6_resume", 20);
        idle(2);
        chk("t6_words", words_done, 1);

        do_clear();
        npop = 0;
        for (int i = 0; i < 800; i++) begin
            en  = ($urandom % 2 == 0) && exp_q.size() <= 12;
            emp = ($urandom % 5 == 0);
            b.out_full_i = ($urandom % 4 == 0);
            if (en && !emp) npop++;
            step(en, emp, {$urandom, $urandom});
        end
        b.out_full_i = 1'b0;
        drain("rnd_drain", 100);
        idle(2);
        chk("rnd_words", words_done, npop);
        chk("rnd_no_ovf", e_ovf, 0);
        chk("rnd_len0_no_done", xfer_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
